mac_mul_mid: RTL

Pipelined operand multiplier stage that consumes decoded operand pairs from two mid-format MAC decoders (iszero, sign, 4-bit exponent, 9-bit mantissa field) and produces a raw, unnormalised product for the downstream MAC aligner/accumulator. Supports FP8 and INT datatypes per transaction. It is a two-register elastic pipeline with valid/ready flow control at both ends. Throughput is one product per cycle.

---
 rtl/tx_pkg.sv | 10 +
 rtl/mac_mul_mid_if.sv | 70 +++++++
 rtl/mac_mul_mid.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared MAC transaction types.
package tx_pkg;

    // Per-transaction operand datatype carried alongside each operand pair.
    typedef enum logic {
        MAC_DATATYPE_FP8 = 1'b0,
        MAC_DATATYPE_INT = 1'b1
    } mac_datatype;

endpackage

// File: rtl/mac_mul_mid_if.sv
// Operand-in / product-out handshake bundle for mac_mul_mid.
// The slave modport is the multiplier's view; master is the producer/consumer side.
interface mac_mul_mid_if;
    import tx_pkg::*;

    // Upstream operand pair from the two mid-format decoders
    logic        i_valid;
    logic        o_ready;
    mac_datatype i_datatype;
    logic        i_a_iszero;
    logic        i_a_sign;
    logic [3:0]  i_a_exp;
    logic [8:0]  i_a_mant;
    logic        i_b_iszero;
    logic        i_b_sign;
    logic [3:0]  i_b_exp;
    logic [8:0]  i_b_mant;

    // Downstream raw product towards the aligner/accumulator
    logic        o_valid;
    logic        i_ready;
    mac_datatype o_datatype;
    logic        o_iszero;
    logic        o_sign;
    logic [4:0]  o_exp;
    logic [17:0] o_mant;

    modport slave (
        input  i_valid,
        output o_ready,
        input  i_datatype,
        input  i_a_iszero,
        input  i_a_sign,
        input  i_a_exp,
        input  i_a_mant,
        input  i_b_iszero,
        input  i_b_sign,
        input  i_b_exp,
        input  i_b_mant,
        output o_valid,
        input  i_ready,
        output o_datatype,
        output o_iszero,
        output o_sign,
        output o_exp,
        output o_mant
    );

    modport master (
        output i_valid,
        input  o_ready,
        output i_datatype,
        output i_a_iszero,
        output i_a_sign,
        output i_a_exp,
        output i_a_mant,
        output i_b_iszero,
        output i_b_sign,
        output i_b_exp,
        output i_b_mant,
        input  o_valid,
        output i_ready,
        input  o_datatype,
        input  o_iszero,
        input  o_sign,
        input  o_exp,
        input  o_mant
    );

endinterface

// File: rtl/mac_mul_mid.sv
// mac_mul_mid: two-stage elastic operand multiplier for the mid-format MAC.
// S1 registers the accepted operand pair, S2 registers the raw unnormalised product.
// FP8 mode: exponent sum of effective exponents, 4x4 unsigned significand product.
// INT mode: 9x9 signed product, sign taken from the product MSB.
// Optional feature macro: MAC_MUL_MID_STAT_EN adds a saturating zero-product
// counter (o_zero_cnt) with a synchronous clear (i_stat_clr).
module mac_mul_mid
    import tx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef MAC_MUL_MID_STAT_EN
    input  logic        i_stat_clr,
    output logic [15:0] o_zero_cnt,
`endif
    mac_mul_mid_if.slave bus
);

    typedef struct packed {
        logic       iszero;
        logic       sign;
        logic [3:0] exponent;
        logic [8:0] mant;
    } operand_t;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic        s1_valid_q, s1_valid_d;
    mac_datatype s1_dt_q;
    operand_t    s1_a_q, s1_b_q;

    logic        s2_valid_q, s2_valid_d;
    mac_datatype s2_dt_q;
    logic        s2_iszero_q;
    logic        s2_sign_q;
    logic [4:0]  s2_exp_q;
    logic [17:0] s2_mant_q;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_move;
    logic in_ready;
    logic in_accept;
    logic s2_load;

    // Handshake decode: S2 advances when empty or drained, S1 when empty or moving.
    always_comb begin
        s1_move    = !s2_valid_q || bus.i_ready;
        in_ready   = !s1_valid_q || s1_move;
        in_accept  = bus.i_valid && in_ready;
        s2_load    = s1_move && s1_valid_q;
        // An empty stage always reloads from its predecessor, so bubbles collapse.
        s1_valid_d = in_ready ? bus.i_valid : s1_valid_q;
        s2_valid_d = s1_move ? s1_valid_q : s2_valid_q;
    end

    // Stage valid flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // S1 operand capture on accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_dt_q <= MAC_DATATYPE_FP8;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
        end else if (in_accept) begin
            s1_dt_q <= bus.i_datatype;
            s1_a_q  <= '{iszero:   bus.i_a_iszero,
                         sign:     bus.i_a_sign,
                         exponent: bus.i_a_exp,
                         mant:     bus.i_a_mant};
            s1_b_q  <= '{iszero:   bus.i_b_iszero,
                         sign:     bus.i_b_sign,
                         exponent: bus.i_b_exp,
                         mant:     bus.i_b_mant};
        end
    end

    // ------------------------------------------------------------------
    // Product datapath (between S1 and S2)
    // ------------------------------------------------------------------
    logic [4:0]         eff_exp_a;
    logic [4:0]         eff_exp_b;
    logic [7:0]         fp_prod;
    logic signed [17:0] int_prod;
    logic               prod_iszero;
    logic               prod_sign;
    logic [4:0]         prod_exp;
    logic [17:0]        prod_mant;

    // Compute the raw product of the operand pair held in S1.
    always_comb begin
        // Subnormals (exp field 0) share the exponent of the smallest normal.
        eff_exp_a = (s1_a_q.exponent == 4'd0) ? 5'd1 : {1'b0, s1_a_q.exponent};
        eff_exp_b = (s1_b_q.exponent == 4'd0) ? 5'd1 : {1'b0, s1_b_q.exponent};
        fp_prod   = {4'b0, s1_a_q.mant[3:0]} * {4'b0, s1_b_q.mant[3:0]};
        int_prod  = $signed({{9{s1_a_q.mant[8]}}, s1_a_q.mant})
                  * $signed({{9{s1_b_q.mant[8]}}, s1_b_q.mant});

        prod_iszero = s1_a_q.iszero | s1_b_q.iszero;
        prod_sign   = 1'b0;
        prod_exp    = '0;
        prod_mant   = '0;

        // A zero operand forces a clean all-zero product in both modes.
        if (!prod_iszero) begin
            if (s1_dt_q == MAC_DATATYPE_FP8) begin
                prod_sign = s1_a_q.sign ^ s1_b_q.sign;
                prod_exp  = eff_exp_a + eff_exp_b;
                prod_mant = {10'b0, fp_prod};
            end else begin
                prod_mant = int_prod;
                prod_sign = int_prod[17];
            end
        end
    end

    // S2 product capture when S1 advances with a valid entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_dt_q     <= MAC_DATATYPE_FP8;
            s2_iszero_q <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_mant_q   <= '0;
        end else if (s2_load) begin
            s2_dt_q     <= s1_dt_q;
            s2_iszero_q <= prod_iszero;
            s2_sign_q   <= prod_sign;
            s2_exp_q    <= prod_exp;
            s2_mant_q   <= prod_mant;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_ready    = in_ready;
    assign bus.o_valid    = s2_valid_q;
    assign bus.o_datatype = s2_dt_q;
    assign bus.o_iszero   = s2_iszero_q;
    assign bus.o_sign     = s2_sign_q;
    assign bus.o_exp      = s2_exp_q;
    assign bus.o_mant     = s2_mant_q;

`ifdef MAC_MUL_MID_STAT_EN
    // ------------------------------------------------------------------
    // Zero-product statistics
    // ------------------------------------------------------------------
    logic [15:0] zero_cnt_q, zero_cnt_d;
    logic        zero_emit;

    // Next count: clear beats increment, increment saturates.
    always_comb begin
        zero_emit  = s2_valid_q && bus.i_ready && s2_iszero_q;
        zero_cnt_d = zero_cnt_q;
        if (i_stat_clr) begin
            zero_cnt_d = '0;
        end else if (zero_emit && (zero_cnt_q != 16'hFFFF)) begin
            zero_cnt_d = zero_cnt_q + 16'd1;
        end
    end

    // Zero-product counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            zero_cnt_q <= '0;
        end else begin
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign o_zero_cnt = zero_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    // A stalled product must not change under the consumer.
    a_hold_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (s2_valid_q && !bus.i_ready) |=>
            (s2_valid_q && $stable({s2_dt_q, s2_iszero_q, s2_sign_q, s2_exp_q, s2_mant_q})));

    // Zero products carry no stray sign/exponent/mantissa bits.
    a_zero_clean: assert property (@(posedge i_clk) disable iff (i_rst)
        (s2_valid_q && s2_iszero_q) |->
            (!s2_sign_q && (s2_exp_q == 5'd0) && (s2_mant_q == 18'd0)));

endmodule
